// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core front end.
package mips_pkg;

    // Decode control bundle: {RegWrite, MemtoReg, MemWrite, ALUControl[2:0], ALUSrc, RegDst}
    localparam int CTRL_W           = 8;
    localparam int CTRL_REGDST      = 0;
    localparam int CTRL_ALUSRC      = 1;
    localparam int CTRL_ALUCTRL_LSB = 2;
    localparam int CTRL_MEMWRITE    = 5;
    localparam int CTRL_MEMTOREG    = 6;
    localparam int CTRL_REGWRITE    = 7;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pipe_reg_en_clr.sv
// Pipeline register with synchronous reset, enable (hold when low) and clear.
// Priority: reset > hold > clear > load.
module pipe_reg_en_clr #(
    parameter int         W       = 32,
    parameter logic [W-1:0] RST_VAL = '0,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // Register update: hold beats clear so a stalled stage keeps its instruction.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so every pipeline stage samples the pre-edge value of its neighbour.
        if (reset)
            r_q <= RST_VAL;
        else if (!en)
            r_q <= r_q;
        else if (clr)
            r_q <= CLR_VAL;
        else
            r_q <= d;
    end

    assign q = r_q;

endmodule

// File: rtl/pipe_front_regs.sv
// Front-end pipeline state: PC, IF/ID and ID/EX registers plus a debug stall counter.
module pipe_front_regs #(
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
    parameter int          CTRL_W   = mips_pkg::CTRL_W,
    parameter int          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StallF,
    input  logic              StallD,
    input  logic              FlushE,
    input  logic              PCSrcD,
    input  logic [31:0]       PCBranchD,
    input  logic              JumpD,
    input  logic [31:0]       PCJumpD,
    input  logic [31:0]       InstrF,
    input  logic [CTRL_W-1:0] CtrlD,
    input  logic [31:0]       RD1D,
    input  logic [31:0]       RD2D,
    input  logic [31:0]       SignImmD,
    input  logic [4:0]        RsD,
    input  logic [4:0]        RtD,
    input  logic [4:0]        RdD,
    output logic [31:0]       PCF,
    output logic [31:0]       InstrD,
    output logic [31:0]       PCPlus4D,
    output logic              ValidD,
    output logic [CTRL_W-1:0] CtrlE,
    output logic [31:0]       RD1E,
    output logic [31:0]       RD2E,
    output logic [31:0]       SignImmE,
    output logic [4:0]        RsE,
    output logic [4:0]        RtE,
    output logic [4:0]        RdE,
    output logic              ValidE,
    output logic [CNT_W-1:0]  StallCount
);

    import mips_pkg::*;

    localparam int IFID_W = 32 + 32 + 1;
    localparam int IDEX_W = CTRL_W + 32 * 3 + 5 * 3 + 1;

    logic [31:0]       w_pcf;
    logic [31:0]       w_pcplus4f;
    logic [31:0]       w_pc_next;
    logic              w_flushd;
    logic [IFID_W-1:0] w_ifid_d;
    logic [IFID_W-1:0] w_ifid_q;
    logic [IDEX_W-1:0] w_idex_d;
    logic [IDEX_W-1:0] w_idex_q;
    logic [CNT_W-1:0]  r_stall_cnt;

    // Next-PC selection: jump outranks branch, both outrank sequential fetch.
    always_comb begin
        w_pcplus4f = w_pcf + 32'd4;
        w_pc_next  = w_pcplus4f;
        if (JumpD)
            w_pc_next = PCJumpD;
        else if (PCSrcD)
            w_pc_next = PCBranchD;
    end

    assign w_flushd = PCSrcD | JumpD;
    assign w_ifid_d = {InstrF, w_pcplus4f, 1'b1};
    assign w_idex_d = {CtrlD, RD1D, RD2D, SignImmD, RsD, RtD, RdD, ValidD};

    pipe_reg_en_clr #(
        .W       (32),
        .RST_VAL (RESET_PC),
        .CLR_VAL ('0)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .en    (~StallF),
        .clr   (1'b0),
        .d     (w_pc_next),
        .q     (w_pcf)
    );

    // Flushed IF/ID slot holds a nop with no valid bit so it writes nothing downstream.
    pipe_reg_en_clr #(
        .W       (IFID_W),
        .RST_VAL ('0),
        .CLR_VAL ({NOP_INSTR, 32'h0, 1'b0})
    ) u_ifid_reg (
        .clk   (clk),
        .reset (reset),
        .en    (~StallD),
        .clr   (w_flushd),
        .d     (w_ifid_d),
        .q     (w_ifid_q)
    );

    // ID/EX never holds; a clear yields an all-zero bubble (RegWrite=MemWrite=0).
    pipe_reg_en_clr #(
        .W       (IDEX_W),
        .RST_VAL ('0),
        .CLR_VAL ('0)
    ) u_idex_reg (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .clr   (FlushE),
        .d     (w_idex_d),
        .q     (w_idex_q)
    );

    // Saturating count of decode-stall cycles, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset)
            r_stall_cnt <= '0;
        else if (StallD && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign PCF = w_pcf;
    assign {InstrD, PCPlus4D, ValidD} = w_ifid_q;
    assign {CtrlE, RD1E, RD2E, SignImmE, RsE, RtE, RdE, ValidE} = w_idex_q;
    assign StallCount = r_stall_cnt;

endmodule
